// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_ST_IDLE   = 3'd0,
    ARB_ST_I_REQ  = 3'd1,
    ARB_ST_I_RESP = 3'd2,
    ARB_ST_D_REQ  = 3'd3,
    ARB_ST_D_RESP = 3'd4
  } arb_state_e;

  typedef enum logic {
    ARB_PORT_I = 1'b0,
    ARB_PORT_D = 1'b1
  } arb_port_e;

  function automatic arb_port_e arb_other(input arb_port_e p);
    return (p == ARB_PORT_I) ? ARB_PORT_D : ARB_PORT_I;
  endfunction

  function automatic logic arb_is_d(input arb_state_e s);
    return (s == ARB_ST_D_REQ) || (s == ARB_ST_D_RESP);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory bus between the fetch and data ports,
// one transaction outstanding, with per-port read hold registers and a watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned D_PRIORITY = 1,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_i_req,
  input  logic [31:0] io_i_addr,
  output logic        io_i_ack,
  output logic [31:0] io_i_rdata,
  input  logic        io_d_req,
  input  logic        io_d_wen,
  input  logic [3:0]  io_d_wstrb,
  input  logic [31:0] io_d_addr,
  input  logic [31:0] io_d_wdata,
  output logic        io_d_ack,
  output logic [31:0] io_d_rdata,
  output logic        io_bus_req,
  output logic [31:0] io_bus_addr,
  output logic        io_bus_wen,
  output logic [3:0]  io_bus_wstrb,
  output logic [31:0] io_bus_wdata,
  input  logic        io_bus_gnt,
  input  logic        io_bus_rvalid,
  input  logic [31:0] io_bus_rdata,
  output logic        io_busy,
  output logic        io_timeout
);

  localparam int unsigned   CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit            WD_EN    = (TIMEOUT != 0);
  localparam bit            D_PRIO   = (D_PRIORITY != 0);

  arb_state_e    state_q;
  arb_port_e     pref_q;
  logic [CW-1:0] cnt_q;
  logic          bus_req_q;
  logic [31:0]   bus_addr_q;
  logic          bus_wen_q;
  logic [3:0]    bus_wstrb_q;
  logic [31:0]   bus_wdata_q;
  logic          i_ack_q;
  logic          d_ack_q;
  logic [31:0]   i_rdata_q;
  logic [31:0]   d_rdata_q;
  logic          timeout_q;

  logic          i_elig;
  logic          d_elig;
  logic          issue;
  arb_port_e     win_port;
  logic          wd_fire;

  // A port whose ack is high this cycle is still holding its old request.
  always_comb begin
    i_elig   = io_i_req & ~i_ack_q;
    d_elig   = io_d_req & ~d_ack_q;
    issue    = i_elig | d_elig;
    win_port = ARB_PORT_I;
    if (d_elig && (!i_elig || D_PRIO || (pref_q == ARB_PORT_D)))
      win_port = ARB_PORT_D;
  end

  assign wd_fire = WD_EN && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_ST_IDLE;
      pref_q      <= ARB_PORT_I;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wen_q   <= 1'b0;
      bus_wstrb_q <= '0;
      bus_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        ARB_ST_IDLE: begin
          if (issue) begin
            cnt_q     <= '0;
            bus_req_q <= 1'b1;
            pref_q    <= arb_other(win_port);
            if (win_port == ARB_PORT_D) begin
              bus_addr_q  <= io_d_addr;
              bus_wen_q   <= io_d_wen;
              bus_wstrb_q <= io_d_wstrb;
              bus_wdata_q <= io_d_wdata;
              state_q     <= ARB_ST_D_REQ;
            end else begin
              bus_addr_q  <= io_i_addr;
              bus_wen_q   <= 1'b0;
              bus_wstrb_q <= '0;
              bus_wdata_q <= '0;
              state_q     <= ARB_ST_I_REQ;
            end
          end
        end
        default: begin
          cnt_q <= cnt_q + 1'b1;
          // Watchdog abort outranks a gnt/rvalid arriving in the same cycle.
          if (wd_fire) begin
            bus_req_q <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= ARB_ST_IDLE;
            if (arb_is_d(state_q)) begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= '0;
            end else begin
              i_ack_q   <= 1'b1;
              i_rdata_q <= '0;
            end
          end else begin
            case (state_q)
              ARB_ST_I_REQ: begin
                if (io_bus_gnt) begin
                  bus_req_q <= 1'b0;
                  state_q   <= ARB_ST_I_RESP;
                end
              end
              ARB_ST_D_REQ: begin
                if (io_bus_gnt) begin
                  bus_req_q <= 1'b0;
                  state_q   <= ARB_ST_D_RESP;
                end
              end
              ARB_ST_I_RESP: begin
                if (io_bus_rvalid) begin
                  i_rdata_q <= io_bus_rdata;
                  i_ack_q   <= 1'b1;
                  state_q   <= ARB_ST_IDLE;
                end
              end
              ARB_ST_D_RESP: begin
                if (io_bus_rvalid) begin
                  if (!bus_wen_q)
                    d_rdata_q <= io_bus_rdata;
                  d_ack_q <= 1'b1;
                  state_q <= ARB_ST_IDLE;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign io_i_ack     = i_ack_q;
  assign io_i_rdata   = i_rdata_q;
  assign io_d_ack     = d_ack_q;
  assign io_d_rdata   = d_rdata_q;
  assign io_bus_req   = bus_req_q;
  assign io_bus_addr  = bus_addr_q;
  assign io_bus_wen   = bus_wen_q;
  assign io_bus_wstrb = bus_wstrb_q;
  assign io_bus_wdata = bus_wdata_q;
  assign io_busy      = (state_q != ARB_ST_IDLE);
  assign io_timeout   = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a data-priority instance checked cycle by cycle from a vector
// table, and a round-robin instance with a short watchdog for the multi-cycle cases.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wen, bus_gnt, bus_rvalid;
  logic [31:0] i_addr, d_addr, d_wdata, bus_rdata;
  logic [3:0]  d_wstrb;

  logic        p_i_ack, p_d_ack, p_bus_req, p_bus_wen, p_busy, p_timeout;
  logic [31:0] p_i_rdata, p_d_rdata, p_bus_addr, p_bus_wdata;
  logic [3:0]  p_bus_wstrb;
  logic        rr_i_ack, rr_d_ack, rr_bus_req, rr_bus_wen, rr_busy, rr_timeout;
  logic [31:0] rr_i_rdata, rr_d_rdata, rr_bus_addr, rr_bus_wdata;
  logic [3:0]  rr_bus_wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.D_PRIORITY(1), .TIMEOUT(255)) u_p (
    .clk(clk), .rst(rst),
    .io_i_req(i_req), .io_i_addr(i_addr), .io_i_ack(p_i_ack), .io_i_rdata(p_i_rdata),
    .io_d_req(d_req), .io_d_wen(d_wen), .io_d_wstrb(d_wstrb), .io_d_addr(d_addr),
    .io_d_wdata(d_wdata), .io_d_ack(p_d_ack), .io_d_rdata(p_d_rdata),
    .io_bus_req(p_bus_req), .io_bus_addr(p_bus_addr), .io_bus_wen(p_bus_wen),
    .io_bus_wstrb(p_bus_wstrb), .io_bus_wdata(p_bus_wdata), .io_bus_gnt(bus_gnt),
    .io_bus_rvalid(bus_rvalid), .io_bus_rdata(bus_rdata), .io_busy(p_busy),
    .io_timeout(p_timeout)
  );

  mem_port_arbiter #(.D_PRIORITY(0), .TIMEOUT(8)) u_rr (
    .clk(clk), .rst(rst),
    .io_i_req(i_req), .io_i_addr(i_addr), .io_i_ack(rr_i_ack), .io_i_rdata(rr_i_rdata),
    .io_d_req(d_req), .io_d_wen(d_wen), .io_d_wstrb(d_wstrb), .io_d_addr(d_addr),
    .io_d_wdata(d_wdata), .io_d_ack(rr_d_ack), .io_d_rdata(rr_d_rdata),
    .io_bus_req(rr_bus_req), .io_bus_addr(rr_bus_addr), .io_bus_wen(rr_bus_wen),
    .io_bus_wstrb(rr_bus_wstrb), .io_bus_wdata(rr_bus_wdata), .io_bus_gnt(bus_gnt),
    .io_bus_rvalid(bus_rvalid), .io_bus_rdata(bus_rdata), .io_busy(rr_busy),
    .io_timeout(rr_timeout)
  );

  typedef struct {
    logic ir; logic [31:0] ia; logic dr; logic dw; logic [3:0] ds; logic [31:0] da; logic [31:0] dd;
    logic g; logic rv; logic [31:0] rd;
    logic br; logic [31:0] ba; logic bw; logic [3:0] bs; logic [31:0] bd;
    logic iack; logic dack; logic [31:0] ird; logic [31:0] drd; logic bsy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic [31:0] ir, ia, dr, dw, ds, da, dd, g, rv, rd,
    input logic [31:0] br, ba, bw, bs, bd, iack, dack, ird, drd, bsy);
    vec_t v;
    v.ir = ir[0]; v.ia = ia; v.dr = dr[0]; v.dw = dw[0]; v.ds = ds[3:0]; v.da = da; v.dd = dd;
    v.g = g[0]; v.rv = rv[0]; v.rd = rd;
    v.br = br[0]; v.ba = ba; v.bw = bw[0]; v.bs = bs[3:0]; v.bd = bd;
    v.iack = iack[0]; v.dack = dack[0]; v.ird = ird; v.drd = drd; v.bsy = bsy[0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wen = 1'b0; d_wstrb = '0;
    d_addr = '0; d_wdata = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst p_bus_req", 32'(p_bus_req), 32'h0);
    chk("rst p_busy", 32'(p_busy), 32'h0);
    chk("rst p_i_rdata", p_i_rdata, 32'h0);
    chk("rst rr_bus_req", 32'(rr_bus_req), 32'h0);
    chk("rst rr_d_rdata", rr_d_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  logic [31:0] iss_addr[4];
  int          n_iss;
  logic        prev_req;

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time bound exceeded");
  end

  initial begin
    // ir  ia        dr dw ds   da      dd            g  rv rd             | br ba      bw bs   bd            ia da ird        drd          bsy
    tbl.push_back(mk(1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h100, 0, 0, 0, 0, 0, 1, 0, 0,                  1, 'h100, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 'h100, 0, 0, 0, 0, 0, 0, 1, 'h13,               0, 'h100, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0,                  0, 'h100, 0, 0, 0, 1, 0, 'h13, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                      0, 'h100, 0, 0, 0, 0, 0, 'h13, 0, 0));
    tbl.push_back(mk(1, 'h300, 1, 1, 'hF, 'h200, 'hDEADBEEF, 0, 0, 0,   0, 'h100, 0, 0, 0, 0, 0, 'h13, 0, 0));
    tbl.push_back(mk(1, 'h300, 1, 1, 'hF, 'h200, 'hDEADBEEF, 1, 0, 0,   1, 'h200, 1, 'hF, 'hDEADBEEF, 0, 0, 'h13, 0, 1));
    tbl.push_back(mk(1, 'h300, 1, 1, 'hF, 'h200, 'hDEADBEEF, 0, 1, 'h55AA55AA, 0, 'h200, 1, 'hF, 'hDEADBEEF, 0, 0, 'h13, 0, 1));
    tbl.push_back(mk(1, 'h300, 1, 1, 'hF, 'h200, 'hDEADBEEF, 0, 0, 0,   0, 'h200, 1, 'hF, 'hDEADBEEF, 0, 1, 'h13, 0, 0));
    tbl.push_back(mk(1, 'h300, 0, 0, 0, 0, 0, 1, 0, 0,                  1, 'h300, 0, 0, 0, 0, 0, 'h13, 0, 1));
    tbl.push_back(mk(1, 'h300, 0, 0, 0, 0, 0, 0, 1, 'hA00093,           0, 'h300, 0, 0, 0, 0, 0, 'h13, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                      0, 'h300, 0, 0, 0, 1, 0, 'hA00093, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 'h400, 0, 0, 1, 'hBAD,              0, 'h300, 0, 0, 0, 0, 0, 'hA00093, 0, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0, 0, 1, 0, 0, 'h400, 0, 0, 0, 0,               1, 'h400, 0, 0, 0, 0, 0, 'hA00093, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 'h400, 0, 1, 1, 'hBAD0,             1, 'h400, 0, 0, 0, 0, 0, 'hA00093, 0, 1));
    for (int k = 0; k < 6; k++)
      tbl.push_back(mk(0, 0, 1, 0, 0, 'h400, 0, 0, 0, 0,               0, 'h400, 0, 0, 0, 0, 0, 'hA00093, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 'h400, 0, 0, 1, 'hCAFEF00D,         0, 'h400, 0, 0, 0, 0, 0, 'hA00093, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 'h400, 0, 0, 0, 0,                  0, 'h400, 0, 0, 0, 0, 1, 'hA00093, 'hCAFEF00D, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                      0, 'h400, 0, 0, 0, 0, 0, 'hA00093, 'hCAFEF00D, 0));

    do_reset();
    foreach (tbl[i]) begin
      i_req = tbl[i].ir; i_addr = tbl[i].ia; d_req = tbl[i].dr; d_wen = tbl[i].dw;
      d_wstrb = tbl[i].ds; d_addr = tbl[i].da; d_wdata = tbl[i].dd;
      bus_gnt = tbl[i].g; bus_rvalid = tbl[i].rv; bus_rdata = tbl[i].rd;
      @(negedge clk);
      chk($sformatf("v%0d bus_req", i), 32'(p_bus_req), 32'(tbl[i].br));
      chk($sformatf("v%0d bus_addr", i), p_bus_addr, tbl[i].ba);
      chk($sformatf("v%0d bus_wen", i), 32'(p_bus_wen), 32'(tbl[i].bw));
      chk($sformatf("v%0d bus_wstrb", i), 32'(p_bus_wstrb), 32'(tbl[i].bs));
      chk($sformatf("v%0d bus_wdata", i), p_bus_wdata, tbl[i].bd);
      chk($sformatf("v%0d i_ack", i), 32'(p_i_ack), 32'(tbl[i].iack));
      chk($sformatf("v%0d d_ack", i), 32'(p_d_ack), 32'(tbl[i].dack));
      chk($sformatf("v%0d i_rdata", i), p_i_rdata, tbl[i].ird);
      chk($sformatf("v%0d d_rdata", i), p_d_rdata, tbl[i].drd);
      chk($sformatf("v%0d busy", i), 32'(p_busy), 32'(tbl[i].bsy));
      chk($sformatf("v%0d timeout", i), 32'(p_timeout), 32'h0);
      @(posedge clk);
      #1;
    end

    // Round robin: both ports held continuously, responder answers the rr instance.
    do_reset();
    i_req = 1'b1; i_addr = 32'h1000; d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h2000;
    n_iss = 0; prev_req = 1'b0;
    for (int k = 0; k < 4; k++) iss_addr[k] = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (rr_bus_req && !prev_req && n_iss < 4) begin
        iss_addr[n_iss] = rr_bus_addr;
        n_iss++;
      end
      prev_req   = rr_bus_req;
      bus_gnt    = rr_bus_req;
      bus_rvalid = rr_busy && !rr_bus_req;
      bus_rdata  = ~rr_bus_addr;
    end
    chk("rr issue count", n_iss, 32'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("rr grant %0d addr", k), iss_addr[k], (k % 2 == 0) ? 32'h1000 : 32'h2000);
    chk("rr i_rdata", rr_i_rdata, ~32'h1000);
    chk("rr d_rdata", rr_d_rdata, ~32'h2000);
    idle_inputs();

    // Watchdog: normal fetch loads the hold reg, then a never-granted fetch aborts after 8 cycles.
    do_reset();
    i_req = 1'b1; i_addr = 32'h600;
    tick();
    chk("wd pre bus_req", 32'(rr_bus_req), 32'h1);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hFFFF0000;
    tick();
    chk("wd pre i_ack", 32'(rr_i_ack), 32'h1);
    chk("wd pre i_rdata", rr_i_rdata, 32'hFFFF0000);
    i_req = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    tick();
    i_req = 1'b1; i_addr = 32'h700;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("wd c%0d bus_req", c), 32'(rr_bus_req), 32'h1);
      chk($sformatf("wd c%0d timeout", c), 32'(rr_timeout), 32'h0);
    end
    tick();
    chk("wd abort bus_req", 32'(rr_bus_req), 32'h0);
    chk("wd abort i_ack", 32'(rr_i_ack), 32'h1);
    chk("wd abort timeout", 32'(rr_timeout), 32'h1);
    chk("wd abort i_rdata", rr_i_rdata, 32'h0);
    chk("wd abort busy", 32'(rr_busy), 32'h0);
    i_req = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1234;
    tick();
    chk("wd late i_ack", 32'(rr_i_ack), 32'h0);
    chk("wd late timeout", 32'(rr_timeout), 32'h0);
    chk("wd late i_rdata", rr_i_rdata, 32'h0);
    chk("wd late busy", 32'(rr_busy), 32'h0);
    bus_rvalid = 1'b0; bus_rdata = '0;

    // Reset during D_RESP, then a fresh fetch.
    do_reset();
    d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h800;
    tick();
    chk("rstmid bus_req", 32'(p_bus_req), 32'h1);
    bus_gnt = 1'b1;
    tick();
    chk("rstmid resp busy", 32'(p_busy), 32'h1);
    bus_gnt = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rstmid async bus_req", 32'(p_bus_req), 32'h0);
    chk("rstmid async busy", 32'(p_busy), 32'h0);
    chk("rstmid async bus_addr", p_bus_addr, 32'h0);
    chk("rstmid async d_ack", 32'(p_d_ack), 32'h0);
    tick();
    chk("rstmid held d_ack", 32'(p_d_ack), 32'h0);
    d_req = 1'b0; d_addr = '0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    i_req = 1'b1; i_addr = 32'h900;
    tick();
    chk("post bus_req", 32'(p_bus_req), 32'h1);
    chk("post bus_addr", p_bus_addr, 32'h900);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h11223344;
    tick();
    chk("post i_ack", 32'(p_i_ack), 32'h1);
    chk("post i_rdata", p_i_rdata, 32'h11223344);
    chk("post d_ack", 32'(p_d_ack), 32'h0);
    chk("post d_rdata", p_d_rdata, 32'h0);
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
